// File: rtl/chat_pkg.sv
// chat_pkg: shared types and constants for the chat terminal session sequencer.
// Holds the session state enum, the two-bit display_state encodings, the user
// ids and the ASCII keys that select a user at the login prompt.
package chat_pkg;

  typedef enum logic [2:0] {
    LOGIN,
    PASSWORD,
    SENDING,
    SEND_WAIT,
    RECEIVING,
    LOCKOUT
  } state_t;

  localparam logic [1:0] DISP_LOGIN     = 2'b00;
  localparam logic [1:0] DISP_PASSWORD  = 2'b01;
  localparam logic [1:0] DISP_SENDING   = 2'b10;
  localparam logic [1:0] DISP_RECEIVING = 2'b11;

  localparam logic [1:0] USER_NONE  = 2'd0;
  localparam logic [1:0] USER_BILLY = 2'd1;
  localparam logic [1:0] USER_BOB   = 2'd2;

  localparam logic [7:0] KEY_BILLY = 8'h31;
  localparam logic [7:0] KEY_BOB   = 8'h32;

  // SEND_WAIT shares the sending screen and LOCKOUT shows the login screen.
  function automatic logic [1:0] disp_of(input state_t s);
    case (s)
      PASSWORD:           return DISP_PASSWORD;
      SENDING, SEND_WAIT: return DISP_SENDING;
      RECEIVING:          return DISP_RECEIVING;
      default:            return DISP_LOGIN;
    endcase
  endfunction

endpackage

// File: rtl/chat_down_counter.sv
// chat_down_counter: loadable 32-bit down counter that saturates at zero.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   clear         - force the count to zero (wins over load)
//   load          - load load_value this edge
//   load_value    - value loaded when load is high
//   zero          - high while the count is zero
module chat_down_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic        zero
);

  logic [31:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  assign zero = (count == 32'd0);

endmodule

// File: rtl/chat_session_ctrl.sv
// chat_session_ctrl: session sequencer for the two-user chat terminal.
// Handles login, password check with lockout, the data_ready/link_done send
// handshake, receive notification with a timed tone, and LCD clear pulses.
// Ports:
//   clock, reset        - system clock, asynchronous active-high reset
//   key_valid/key_ascii - decoded keypad strobe and ASCII code
//   logout              - level; return to the login prompt
//   send_req            - user commits a message
//   link_done           - link write finished
//   link_received       - a message arrived
//   display_state       - 00 login, 01 password, 10 sending, 11 receiving
//   user_id             - 0 none, 1 Billy, 2 Bob
//   data_ready          - request toward the link
//   lcd_clear           - one-cycle LCD clear pulse
//   tone_en             - receive tone enable
//   locked              - high during lockout
//   send_err            - one-cycle pulse when a send times out
//   fail_count          - consecutive wrong passwords
module chat_session_ctrl
  import chat_pkg::*;
#(
  parameter int unsigned TONE_CYCLES  = 1250000,
  parameter int unsigned LOCK_CYCLES  = 50000000,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned SEND_TIMEOUT = 5000000,
  parameter logic [7:0]  PWD_BILLY    = 8'h30,
  parameter logic [7:0]  PWD_BOB      = 8'h31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  input  logic       logout,
  input  logic       send_req,
  input  logic       link_done,
  input  logic       link_received,
  output logic [1:0] display_state,
  output logic [1:0] user_id,
  output logic       data_ready,
  output logic       lcd_clear,
  output logic       tone_en,
  output logic       locked,
  output logic       send_err,
  output logic [1:0] fail_count
);

  localparam logic [1:0]  MAX_FAIL   = 2'(MAX_TRIES);
  // Both reloads are one short so the zero-detect edge lands exactly
  // LOCK_CYCLES / SEND_TIMEOUT clocks after entry.
  localparam logic [31:0] LOCK_LOAD  = LOCK_CYCLES - 32'd1;
  localparam logic [31:0] TMO_LOAD   = SEND_TIMEOUT - 32'd1;
  localparam logic [31:0] TONE_LOAD  = TONE_CYCLES;

  state_t     state, state_n;
  logic [1:0] user_n, fail_n, fail_inc;
  logic       data_ready_n, lcd_clear_n, send_err_n;
  logic       rx_pending, rx_pending_n;
  logic       tone_load, tone_clear, lock_load, tmo_load;
  logic       tone_zero, lock_zero, tmo_zero;
  logic [7:0] user_pwd;

  chat_down_counter u_tone (
    .clock(clock), .reset(reset), .clear(tone_clear), .load(tone_load),
    .load_value(TONE_LOAD), .zero(tone_zero)
  );

  chat_down_counter u_lock (
    .clock(clock), .reset(reset), .clear(1'b0), .load(lock_load),
    .load_value(LOCK_LOAD), .zero(lock_zero)
  );

  chat_down_counter u_timeout (
    .clock(clock), .reset(reset), .clear(1'b0), .load(tmo_load),
    .load_value(TMO_LOAD), .zero(tmo_zero)
  );

  assign user_pwd = (user_id == USER_BOB) ? PWD_BOB : PWD_BILLY;
  assign fail_inc = (fail_count == MAX_FAIL) ? fail_count : fail_count + 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= LOGIN;
      user_id    <= USER_NONE;
      fail_count <= 2'd0;
      data_ready <= 1'b0;
      lcd_clear  <= 1'b0;
      send_err   <= 1'b0;
      rx_pending <= 1'b0;
    end else begin
      state      <= state_n;
      user_id    <= user_n;
      fail_count <= fail_n;
      data_ready <= data_ready_n;
      lcd_clear  <= lcd_clear_n;
      send_err   <= send_err_n;
      rx_pending <= rx_pending_n;
    end
  end

  always_comb begin
    state_n      = state;
    user_n       = user_id;
    fail_n       = fail_count;
    data_ready_n = data_ready;
    lcd_clear_n  = 1'b0;
    send_err_n   = 1'b0;
    rx_pending_n = rx_pending;
    tone_load    = 1'b0;
    tone_clear   = 1'b0;
    lock_load    = 1'b0;
    tmo_load     = 1'b0;

    // logout is a level, so a held logout in LOGIN must not keep strobing
    // the LCD; fail_count survives so lockout cannot be dodged.
    if (logout && state != LOCKOUT) begin
      state_n      = LOGIN;
      user_n       = USER_NONE;
      data_ready_n = 1'b0;
      rx_pending_n = 1'b0;
      tone_clear   = 1'b1;
      lcd_clear_n  = (state != LOGIN);
    end else begin
      case (state)
        LOGIN: begin
          if (key_valid && key_ascii == KEY_BILLY) begin
            user_n      = USER_BILLY;
            state_n     = PASSWORD;
            lcd_clear_n = 1'b1;
          end else if (key_valid && key_ascii == KEY_BOB) begin
            user_n      = USER_BOB;
            state_n     = PASSWORD;
            lcd_clear_n = 1'b1;
          end
        end
        PASSWORD: begin
          if (key_valid) begin
            lcd_clear_n = 1'b1;
            if (key_ascii == user_pwd) begin
              state_n = SENDING;
              fail_n  = 2'd0;
            end else begin
              fail_n = fail_inc;
              if (fail_inc == MAX_FAIL) begin
                state_n   = LOCKOUT;
                lock_load = 1'b1;
              end
            end
          end
        end
        LOCKOUT: begin
          if (lock_zero) begin
            state_n     = LOGIN;
            user_n      = USER_NONE;
            fail_n      = 2'd0;
            lcd_clear_n = 1'b1;
          end
        end
        SENDING: begin
          // A receive deferred during SEND_WAIT is serviced like a fresh one.
          if (link_received || rx_pending) begin
            state_n      = RECEIVING;
            lcd_clear_n  = 1'b1;
            tone_load    = 1'b1;
            rx_pending_n = 1'b0;
          end else if (send_req) begin
            state_n      = SEND_WAIT;
            data_ready_n = 1'b1;
            tmo_load     = 1'b1;
          end
        end
        SEND_WAIT: begin
          if (link_received) begin
            rx_pending_n = 1'b1;
          end
          if (link_done) begin
            state_n      = SENDING;
            data_ready_n = 1'b0;
          end else if (tmo_zero) begin
            state_n      = SENDING;
            data_ready_n = 1'b0;
            send_err_n   = 1'b1;
          end
        end
        RECEIVING: begin
          if (link_received) begin
            lcd_clear_n = 1'b1;
            tone_load   = 1'b1;
          end
          if (key_valid) begin
            state_n     = SENDING;
            lcd_clear_n = 1'b1;
          end
        end
        default: state_n = LOGIN;
      endcase
    end
  end

  assign display_state = disp_of(state);
  assign locked        = (state == LOCKOUT);
  assign tone_en       = ~tone_zero;

endmodule

// File: tb/tb_chat_session_ctrl.sv
// Self-checking bench for chat_session_ctrl. A behavioural session model,
// written in terms of "clocks remaining" rather than counters, predicts the
// outputs each cycle; the driver queues the prediction and a negedge monitor
// pops and compares it against the DUT.
module tb_chat_session_ctrl;

  localparam int TONE  = 16;
  localparam int LOCK  = 20;
  localparam int TRIES = 3;
  localparam int TMO   = 10;

  localparam int M_LOGIN = 0, M_PWD = 1, M_SEND = 2, M_WAIT = 3, M_RECV = 4, M_LOCK = 5;

  typedef struct {
    logic [1:0] disp;
    logic [1:0] user;
    logic [1:0] fails;
    logic       dr;
    logic       clr;
    logic       tone;
    logic       locked;
    logic       err;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_ascii = 8'h00;
  logic       logout = 1'b0;
  logic       send_req = 1'b0;
  logic       link_done = 1'b0;
  logic       link_received = 1'b0;
  logic [1:0] display_state, user_id, fail_count;
  logic       data_ready, lcd_clear, tone_en, locked, send_err;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  int m_mode, m_user, m_fails, m_lock_left, m_wait_left, m_tone_left;
  bit m_pend, m_dr, m_clr, m_err;

  chat_session_ctrl #(
    .TONE_CYCLES(TONE), .LOCK_CYCLES(LOCK), .MAX_TRIES(TRIES),
    .SEND_TIMEOUT(TMO), .PWD_BILLY(8'h30), .PWD_BOB(8'h31)
  ) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_ascii(key_ascii),
    .logout(logout), .send_req(send_req), .link_done(link_done),
    .link_received(link_received), .display_state(display_state),
    .user_id(user_id), .data_ready(data_ready), .lcd_clear(lcd_clear),
    .tone_en(tone_en), .locked(locked), .send_err(send_err),
    .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_mode = M_LOGIN; m_user = 0; m_fails = 0;
    m_lock_left = 0; m_wait_left = 0; m_tone_left = 0;
    m_pend = 0; m_dr = 0; m_clr = 0; m_err = 0;
  endfunction

  // One clock of session behaviour given the inputs seen at that edge.
  function automatic void model_step(input bit kv, input logic [7:0] ka,
                                     input bit lo, input bit sr,
                                     input bit ld, input bit lr);
    m_clr = 0;
    m_err = 0;
    if (m_tone_left > 0) m_tone_left--;
    if (lo && m_mode != M_LOCK) begin
      if (m_mode != M_LOGIN) m_clr = 1;
      m_mode = M_LOGIN; m_user = 0; m_dr = 0; m_pend = 0; m_tone_left = 0;
      return;
    end
    case (m_mode)
      M_LOGIN: if (kv && (ka == 8'h31 || ka == 8'h32)) begin
        m_user = int'(ka) - 48; m_mode = M_PWD; m_clr = 1;
      end
      M_PWD: if (kv) begin
        m_clr = 1;
        if (ka == ((m_user == 2) ? 8'h31 : 8'h30)) begin
          m_mode = M_SEND; m_fails = 0;
        end else begin
          if (m_fails < TRIES) m_fails++;
          if (m_fails == TRIES) begin
            m_mode = M_LOCK; m_lock_left = LOCK;
          end
        end
      end
      M_LOCK: begin
        m_lock_left--;
        if (m_lock_left == 0) begin
          m_mode = M_LOGIN; m_user = 0; m_fails = 0; m_clr = 1;
        end
      end
      M_SEND: begin
        if (lr || m_pend) begin
          m_mode = M_RECV; m_clr = 1; m_tone_left = TONE; m_pend = 0;
        end else if (sr) begin
          m_mode = M_WAIT; m_dr = 1; m_wait_left = TMO;
        end
      end
      M_WAIT: begin
        if (lr) m_pend = 1;
        if (ld) begin
          m_mode = M_SEND; m_dr = 0;
        end else begin
          m_wait_left--;
          if (m_wait_left == 0) begin
            m_mode = M_SEND; m_dr = 0; m_err = 1;
          end
        end
      end
      M_RECV: begin
        if (lr) begin
          m_clr = 1; m_tone_left = TONE;
        end
        if (kv) begin
          m_mode = M_SEND; m_clr = 1;
        end
      end
      default: m_mode = M_LOGIN;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    case (m_mode)
      M_PWD:          e.disp = 2'b01;
      M_SEND, M_WAIT: e.disp = 2'b10;
      M_RECV:         e.disp = 2'b11;
      default:        e.disp = 2'b00;
    endcase
    e.user   = 2'(m_user);
    e.fails  = 2'(m_fails);
    e.dr     = m_dr;
    e.clr    = m_clr;
    e.tone   = (m_tone_left > 0);
    e.locked = (m_mode == M_LOCK);
    e.err    = m_err;
    return e;
  endfunction

  // Queue the outputs expected after the edge just passed, then drive the
  // inputs for the next edge and advance the model over it.
  task automatic applyStimulus(input bit rst, input bit kv, input logic [7:0] ka,
                               input bit lo, input bit sr, input bit ld, input bit lr);
    @(posedge clock);
    #1;
    reset = rst;
    if (rst) model_reset();
    exp_q.push_back(model_out());
    key_valid     = kv && !rst;
    key_ascii     = ka;
    logout        = lo && !rst;
    send_req      = sr && !rst;
    link_done     = ld && !rst;
    link_received = lr && !rst;
    if (!rst) model_step(kv, ka, lo, sr, ld, lr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic press(input logic [7:0] k);
    applyStimulus(0, 1, k, 0, 0, 0, 0);
  endtask

  task automatic cmpField(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField("display_state", 8'(display_state), 8'(e.disp));
    cmpField("user_id",       8'(user_id),       8'(e.user));
    cmpField("fail_count",    8'(fail_count),    8'(e.fails));
    cmpField("data_ready",    8'(data_ready),    8'(e.dr));
    cmpField("lcd_clear",     8'(lcd_clear),     8'(e.clr));
    cmpField("tone_en",       8'(tone_en),       8'(e.tone));
    cmpField("locked",        8'(locked),        8'(e.locked));
    cmpField("send_err",      8'(send_err),      8'(e.err));
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    logic [7:0] keys [5];
    keys = '{8'h30, 8'h31, 8'h32, 8'h35, 8'h61};
    model_reset();
    $display("[TB] start");

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'h00, 0, 0, 0, 0);
    idle(2);

    // Billy logs in with the right password.
    press(8'h31); press(8'h30); idle(2);

    // Handshake completed by link_done seven clocks later.
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0);
    idle(6);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 0);
    idle(2);

    // Handshake abandoned by timeout.
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0);
    idle(14);

    // Receive deferred during SEND_WAIT, then tone runs out.
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0);
    idle(2);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
    idle(2);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 1);
    idle(20);
    press(8'h61); idle(2);

    // send_req and link_received together: receive wins.
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 1);
    idle(3);
    press(8'h20); idle(1);

    // Bob fails three times; logout during lockout is ignored.
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    press(8'h32); press(8'h35); press(8'h35); press(8'h35);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'h31, 1, 0, 0, 0);
    idle(20);

    // Bob logs in, then reset lands mid-handshake.
    press(8'h32); press(8'h31);
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0);
    idle(3);
    applyStimulus(1, 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0, 0, 0);
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(0,
                    $urandom_range(0, 3) == 0,
                    keys[$urandom_range(0, 4)],
                    $urandom_range(0, 63) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0);
    end
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chat_session_ctrl.md
Name: chat_session_ctrl

Overview:
Clocked session sequencer for the two-user chat terminal. It replaces the ad-hoc display_state logic with a single FSM and owns five things: login, password check with lockout, the data_ready/done send handshake toward gpio_protocol, receive notification, and LCD clear pulses. Its outputs drive the prompt/display muxes, the lcd reset, gpio_protocol data_ready and the audio tone enable.

Parameters:
TONE_CYCLES, 1250000, clocks tone_en stays high after a receive
LOCK_CYCLES, 50000000, lockout duration in clocks
MAX_TRIES, 3, consecutive wrong passwords before lockout
SEND_TIMEOUT, 5000000, max clocks waiting for link_done
PWD_BILLY, 8'h30, password key for user 1 ('0')
PWD_BOB, 8'h31, password key for user 2 ('1')

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle pulse; key_ascii valid
key_ascii  in  8  ASCII of decoded key
logout  in  1  level, synchronous to clock; return to login
send_req  in  1  one-cycle pulse; user commits message
link_done  in  1  one-cycle pulse; gpio_protocol write complete
link_received  in  1  one-cycle pulse; message arrived
display_state  out  2  00 login, 01 password, 10 sending, 11 receiving
user_id  out  2  0 none, 1 Billy, 2 Bob
data_ready  out  1  request to gpio_protocol
lcd_clear  out  1  one-cycle pulse to lcd reset
tone_en  out  1  receive tone enable
locked  out  1  high during lockout
send_err  out  1  one-cycle pulse on send timeout
fail_count  out  2  current wrong-password count

Behaviour:
- Reset: state LOGIN. All outputs 0, all counters 0.
- States and display_state encoding: LOGIN 00, PASSWORD 01, SENDING 10, SEND_WAIT 10, RECEIVING 11, LOCKOUT 00 (locked=1).
- All outputs are registered. Each transition takes effect on the clock edge after the triggering pulse.
- LOGIN, on key_valid:
  - 8'h31 → user_id=1, PASSWORD, lcd_clear.
  - 8'h32 → user_id=2, PASSWORD, lcd_clear.
  - Any other key is ignored.
- PASSWORD, on key_valid:
  - Key equals the password for user_id → SENDING, fail_count=0, lcd_clear.
  - Otherwise fail_count+1 and lcd_clear. If the new count equals MAX_TRIES → LOCKOUT and reload the lock counter with LOCK_CYCLES-1.
- LOCKOUT:
  - Counter decrements each clock; key_valid and logout are ignored.
  - At 0 → LOGIN, user_id=0, fail_count=0, locked=0, lcd_clear.
- SENDING:
  - send_req → data_ready=1, SEND_WAIT, timeout counter reloaded.
  - link_received → RECEIVING, lcd_clear, tone counter loaded with TONE_CYCLES.
  - Both in the same cycle: receive wins and send_req is dropped.
- SEND_WAIT:
  - data_ready held 1.
  - link_done → data_ready=0 next edge, SENDING.
  - Timeout counter reaching 0 → data_ready=0, send_err pulse, SENDING.
  - link_received here sets rx_pending and does not change state. rx_pending is serviced on return to SENDING, same as a link_received pulse, one cycle later.
  - link_done and link_received in the same cycle: done is honoured and rx_pending is set.
- RECEIVING:
  - key_valid (any key) → SENDING, lcd_clear.
  - link_received → lcd_clear and tone reload; state unchanged.
- tone_en = (tone counter != 0). The counter decrements each clock and saturates at 0; it runs independently of state.
- logout (non-LOCKOUT), highest priority below reset:
  - → LOGIN, user_id=0, data_ready=0, rx_pending=0, tone counter=0, lcd_clear.
  - fail_count is kept, so logout cannot be used to bypass lockout.
- Reset mid-handshake: data_ready drops asynchronously with reset; no send_err.
- Counter widths: 32 bits, unsigned. fail_count saturates at MAX_TRIES.

Decomposition:
- Package chat_pkg holds:
  - state enum: LOGIN, PASSWORD, SENDING, SEND_WAIT, RECEIVING, LOCKOUT;
  - display encodings: DISP_LOGIN / DISP_PASSWORD / DISP_SENDING / DISP_RECEIVING;
  - user ids and ASCII key constants.
- One sub-module, chat_down_counter: loadable 32-bit saturating down counter with a zero flag. It is instantiated three times: tone, lockout, send timeout.

Test Plan:
- Login and password: key 8'h31 then 8'h30 → display_state 00→01→10, user_id=1, lcd_clear two single-cycle pulses, fail_count=0.
- Lockout (MAX_TRIES=3, LOCK_CYCLES=20): user 2, keys 8'h35 ×3 → fail_count 1,2,3, locked=1. Stay in LOCKOUT exactly 20 clocks, then LOGIN with user_id=0. logout asserted during lockout has no effect.
- Send handshake: in SENDING, send_req → data_ready=1 next edge. link_done 7 clocks later → data_ready=0 next edge, display_state=10.
- Send timeout (SEND_TIMEOUT=10): send_req with no link_done → data_ready high 10 clocks, then 0, with a one-cycle send_err.
- Receive during send: link_received in SEND_WAIT, then link_done → SENDING, then RECEIVING one cycle later. tone_en high TONE_CYCLES (test value 16) clocks. Any key → display_state=10.
- Simultaneous events: send_req and link_received in the same cycle → RECEIVING, data_ready stays 0. Async reset mid-SEND_WAIT → all outputs 0 immediately.
